// File: rtl/rr_pkg.sv
// rr_pkg: shared constants for the two-input round-robin merge.
// Source tags, default width and a tag-to-onehot helper.
package rr_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic logic [1:0] src_oh(
    input logic s
  );
    return (s == SRC_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with priority and packet lock.
// Packet lock exists only when RR_MERGE2_LAST_EN is defined.
module rr_arb2
  import rr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last,
  output logic [1:0] gnt
);

  logic       pri;
  logic [1:0] rr_gnt;
  logic       gnt_src;

  // Plain round-robin choice; pri only matters when both request
  always_comb begin
    rr_gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b01): rr_gnt = 2'b01;
      (req == 2'b10): rr_gnt = 2'b10;
      (req == 2'b11): rr_gnt = src_oh(pri);
      default:        rr_gnt = 2'b00;
    endcase
  end

  assign gnt_src = gnt[1] ? SRC_B : SRC_A;

`ifdef RR_MERGE2_LAST_EN

  logic lock;
  logic lk_src;

  // Mid-packet, only the owning source may be granted
  always_comb begin
    gnt = rr_gnt;
    if (lock) begin
      gnt = req & src_oh(lk_src);
    end
  end

  // Priority turns over only at packet boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri    <= SRC_A;
      lock   <= 1'b0;
      lk_src <= SRC_A;
    end else if (advance) begin
      lock   <= !last;
      lk_src <= gnt_src;
      if (last) begin
        pri <= ~gnt_src;
      end
    end
  end

`else

  logic unused_last;

  assign unused_last = last;

  // Per-beat arbitration: grant is the round-robin choice
  always_comb begin
    gnt = rr_gnt;
  end

  // Served source loses priority for the next contested cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri <= SRC_A;
    end else if (advance) begin
      pri <= ~gnt_src;
    end
  end

`endif

endmodule

// File: rtl/rr_merge2.sv
// rr_merge2: two-input round-robin stream merge, registered output.
// Define RR_MERGE2_LAST_EN for packet mode (grant held until last).
module rr_merge2
  import rr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_src,
  output logic             y_last,
  input  logic             y_ready
);

  logic [1:0]       gnt;
  logic             can_load;
  logic             load;
  logic             sel_src;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  // Output slot free now, or drained this cycle; never while in reset
  assign can_load = rst_n && (!y_valid || y_ready);

  assign a_ready = gnt[0] && can_load;
  assign b_ready = gnt[1] && can_load;
  assign load    = a_ready || b_ready;

  assign sel_src  = gnt[1] ? SRC_B : SRC_A;
  assign sel_data = gnt[1] ? b_data : a_data;

`ifdef RR_MERGE2_LAST_EN
  assign sel_last = gnt[1] ? b_last : a_last;
`else
  logic unused_lasts;

  assign unused_lasts = a_last ^ b_last;
  assign sel_last     = 1'b0;
`endif

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({b_valid, a_valid}),
    .advance (load),
    .last    (sel_last),
    .gnt     (gnt)
  );

  // Output beat register: load wins over drain, so no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_src   <= SRC_A;
      y_last  <= 1'b0;
    end else if (load) begin
      y_valid <= 1'b1;
      y_data  <= sel_data;
      y_src   <= sel_src;
      y_last  <= sel_last;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_merge2.sv
// tb_rr_merge2: vectors, corner sequences and a random model check.
// Packet-mode sequence is built only with RR_MERGE2_LAST_EN.
module tb_rr_merge2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic [7:0] a_data, b_data;
  logic       a_last, b_last;
  logic       a_ready, b_ready;
  logic       y_valid;
  logic [7:0] y_data;
  logic       y_src, y_last;
  logic       y_ready;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_merge2 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_src   (y_src),
    .y_last  (y_last),
    .y_ready (y_ready)
  );

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       yr;
    logic       ear;
    logic       ebr;
    logic       eyv;
    logic [7:0] eyd;
    logic       eys;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = 8'h00;
    b_data  = 8'h00;
    a_last  = 1'b0;
    b_last  = 1'b0;
    y_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_in();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state: one output slot plus last-served source
  logic       m_v;
  logic [7:0] m_d;
  logic       m_s;
  int         m_served;

  task automatic model_reset();
    m_v      = 1'b0;
    m_d      = 8'h00;
    m_s      = 1'b0;
    m_served = 1;
  endtask

  initial begin
    logic a_took, b_took, free;
    int   want;
    rst_n = 1'b0;
    idle_in();

    // Ready must stay low while reset is held, even with requests
    #2;
    a_valid = 1'b1;
    b_valid = 1'b1;
    y_ready = 1'b1;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_y_valid", y_valid, 0);
    do_reset();

    // Idle for 5 cycles after release
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_y_valid", y_valid, 0);
      chk("idle_y_src", y_src, 0);
      chk("idle_a_ready", a_ready, 0);
      chk("idle_b_ready", b_ready, 0);
      @(negedge clk);
    end

    // Vector table, applied in order from a fresh reset
    tbl[0]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
    tbl[1]  = '{1, 8'h3C, 0, 8'h00, 1, 1, 0, 1, 8'h3C, 0};
    tbl[2]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h3C, 0};
    tbl[3]  = '{1, 8'h11, 1, 8'h22, 1, 0, 1, 1, 8'h22, 1};
    tbl[4]  = '{1, 8'h11, 1, 8'h33, 1, 1, 0, 1, 8'h11, 0};
    tbl[5]  = '{1, 8'h44, 1, 8'h33, 1, 0, 1, 1, 8'h33, 1};
    tbl[6]  = '{1, 8'h44, 1, 8'h55, 0, 0, 0, 1, 8'h33, 1};
    tbl[7]  = '{0, 8'h00, 1, 8'h55, 0, 0, 0, 1, 8'h33, 1};
    tbl[8]  = '{0, 8'h00, 1, 8'h55, 1, 0, 1, 1, 8'h55, 1};
    tbl[9]  = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h55, 1};
    tbl[10] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h55, 1};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      a_valid = tbl[i].av;
      a_data  = tbl[i].ad;
      b_valid = tbl[i].bv;
      b_data  = tbl[i].bd;
      y_ready = tbl[i].yr;
      #1;
      chk($sformatf("tbl%0d_a_ready", i), a_ready, tbl[i].ear);
      chk($sformatf("tbl%0d_b_ready", i), b_ready, tbl[i].ebr);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_y_valid", i), y_valid, tbl[i].eyv);
      chk($sformatf("tbl%0d_y_data", i), y_data, tbl[i].eyd);
      chk($sformatf("tbl%0d_y_src", i), y_src, tbl[i].eys);
      @(negedge clk);
    end

    // Single A beat: ready in the same cycle, output one edge later
    do_reset();
    a_valid = 1'b1;
    a_data  = 8'h3C;
    y_ready = 1'b1;
    #1;
    chk("one_a_ready", a_ready, 1);
    @(posedge clk);
    #1;
    chk("one_y_valid", y_valid, 1);
    chk("one_y_data", y_data, 8'h3C);
    chk("one_y_src", y_src, 0);
    @(negedge clk);
    a_valid = 1'b0;

    // Both continuously valid: A,B,A,B starting with A after reset
    do_reset();
    a_valid = 1'b1;
    a_data  = 8'h11;
    b_valid = 1'b1;
    b_data  = 8'h22;
    y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      a_took = a_ready;
      b_took = b_ready;
      chk("alt_a_ready", a_took, (i % 2) == 0);
      chk("alt_b_ready", b_took, (i % 2) == 1);
      @(posedge clk);
      #1;
      chk("alt_y_src", y_src, i % 2);
      want = (i % 2 == 0) ? 8'h11 + i / 2 : 8'h22 + i / 2;
      chk("alt_y_data", y_data, want);
      @(negedge clk);
      if (a_took) a_data = a_data + 8'h01;
      if (b_took) b_data = b_data + 8'h01;
    end

    // Downstream stall holds the beat and blocks B
    do_reset();
    a_valid = 1'b1;
    a_data  = 8'h55;
    y_ready = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b1;
    b_data  = 8'h66;
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_b_ready", b_ready, 0);
      chk("stall_y_valid", y_valid, 1);
      chk("stall_y_data", y_data, 8'h55);
      chk("stall_y_src", y_src, 0);
      @(negedge clk);
    end
    y_ready = 1'b1;
    #1;
    chk("unstall_b_ready", b_ready, 1);
    @(posedge clk);
    #1;
    chk("unstall_y_valid", y_valid, 1);
    chk("unstall_y_data", y_data, 8'h66);
    chk("unstall_y_src", y_src, 1);

    // Asynchronous reset discards the held beat before any edge
    @(negedge clk);
    b_valid = 1'b0;
    y_ready = 1'b0;
    a_valid = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("arst_y_valid", y_valid, 0);
    chk("arst_y_data", y_data, 0);
    chk("arst_a_ready", a_ready, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    a_data  = 8'h77;
    b_valid = 1'b1;
    b_data  = 8'h88;
    y_ready = 1'b1;
    #1;
    chk("post_a_ready", a_ready, 1);
    chk("post_b_ready", b_ready, 0);
    @(posedge clk);
    #1;
    chk("post_y_src", y_src, 0);
    chk("post_y_data", y_data, 8'h77);

`ifdef RR_MERGE2_LAST_EN
    // A 3-beat packet keeps the grant even though B is waiting
    do_reset();
    a_valid = 1'b1;
    b_valid = 1'b1;
    b_data  = 8'hB1;
    b_last  = 1'b1;
    y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) a_valid = 1'b0;
      a_data = 8'hA1 + i[7:0];
      a_last = (i == 2);
      #1;
      chk("pkt_b_ready", b_ready, i == 3);
      @(posedge clk);
      #1;
      chk("pkt_y_src", y_src, i == 3);
      chk("pkt_y_last", y_last, i >= 2);
      @(negedge clk);
    end
    b_valid = 1'b0;
`endif

    // Random traffic against the reference model
    do_reset();
    model_reset();
    a_took = 1'b0;
    b_took = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      chk("rnd_y_valid", y_valid, m_v);
      if (m_v) begin
        chk("rnd_y_data", y_data, m_d);
        chk("rnd_y_src", y_src, m_s);
      end
`ifndef RR_MERGE2_LAST_EN
      chk("rnd_y_last", y_last, 0);
`endif
      if (!a_valid || a_took) begin
        a_valid = $urandom_range(0, 3) != 0;
        a_data  = 8'($urandom);
      end
      if (!b_valid || b_took) begin
        b_valid = $urandom_range(0, 3) != 0;
        b_data  = 8'($urandom);
      end
`ifdef RR_MERGE2_LAST_EN
      a_last = 1'b1;
      b_last = 1'b1;
`else
      a_last = 1'($urandom);
      b_last = 1'($urandom);
`endif
      y_ready = $urandom_range(0, 3) != 0;
      #1;
      free = !m_v || y_ready;
      want = -1;
      if (a_valid && b_valid) want = (m_served == 0) ? 1 : 0;
      else if (a_valid) want = 0;
      else if (b_valid) want = 1;
      a_took = free && want == 0;
      b_took = free && want == 1;
      chk("rnd_a_ready", a_ready, a_took);
      chk("rnd_b_ready", b_ready, b_took);
      if (a_took || b_took) begin
        m_v      = 1'b1;
        m_d      = a_took ? a_data : b_data;
        m_s      = b_took;
        m_served = want;
      end else if (y_ready) begin
        m_v = 1'b0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
